// File: rtl/store_commit_drainer.sv
// store_commit_drainer: walks the store-queue head, writes each committed
// store into the D-cache (valid/ack/nack), waits out refills on a miss and
// hands each freed entry back to the store queue.
module store_commit_drainer #(
  parameter int ENTRY_NUM    = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int LOCK_CYCLES  = 5,
  localparam int IDX_W = $clog2(ENTRY_NUM),
  localparam int CW_W  = $clog2(COMMIT_WIDTH + 1),
  localparam int BE_W  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CW_W-1:0]       commitCount,
  output logic [IDX_W-1:0]      sqHeadPtr,
  input  logic [ADDR_WIDTH-3:0] sqAddr,
  input  logic [DATA_WIDTH-1:0] sqData,
  input  logic [BE_W-1:0]       sqByteWE,
  input  logic                  sqCondEnabled,
  output logic                  dcWriteReq,
  output logic [ADDR_WIDTH-1:0] dcWriteAddr,
  output logic [DATA_WIDTH-1:0] dcWriteData,
  output logic [BE_W-1:0]       dcWriteByteWE,
  input  logic                  dcWriteAck,
  input  logic                  dcWriteNack,
  input  logic                  dcMissDone,
  output logic                  releaseValid,
  output logic [IDX_W:0]        pendingCount,
  output logic                  drainEmpty
);

  // One spare bit over the pending width so an overflowing commit is visible.
  localparam int PW   = IDX_W + 2;
  localparam int LK_W = $clog2(LOCK_CYCLES + 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_MISS = 2'd2,
    LOCK      = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  head_reg;
  logic [IDX_W:0]    pending_reg;
  logic [IDX_W:0]    pending_next;
  logic [PW-1:0]     pend_sum;
  logic [LK_W-1:0]   lock_reg;
  logic              write_req;
  logic              release_valid;

  // Pending entries after this cycle's commits and release are both applied.
  always_comb begin
    pend_sum     = PW'(pending_reg) + PW'(commitCount) - PW'(release_valid);
    pending_next = pend_sum[IDX_W:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. The lock phase is sized so that a refill completing in
  // cycle t yields the retry request in cycle t+LOCK_CYCLES; with one or zero
  // lock cycles the lock phase is skipped entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg != '0) state_next = REQ;
      end
      REQ: begin
        if (release_valid) begin
          state_next = (pending_next != '0) ? REQ : IDLE;
        end else if (dcWriteNack) begin
          state_next = WAIT_MISS;
        end
      end
      WAIT_MISS: begin
        if (dcMissDone) state_next = (LOCK_CYCLES <= 1) ? REQ : LOCK;
      end
      LOCK: begin
        if (lock_reg <= LK_W'(1)) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: a write is requested only for a live head entry; a failed
  // store-conditional is released without touching the cache. Ack wins
  // over a simultaneous nack.
  always_comb begin
    write_req     = (state_reg == REQ) && sqCondEnabled;
    release_valid = (state_reg == REQ) && (!sqCondEnabled || dcWriteAck);
    dcWriteReq    = write_req;
    releaseValid  = release_valid;
    dcWriteAddr   = write_req ? {sqAddr, 2'b00} : '0;
    dcWriteData   = write_req ? sqData : '0;
    dcWriteByteWE = write_req ? sqByteWE : '0;
    sqHeadPtr     = head_reg;
    pendingCount  = pending_reg;
    drainEmpty    = (pending_reg == '0) && (state_reg == IDLE);
  end

  // Head pointer, pending counter and lock countdown. The head wraps
  // naturally because ENTRY_NUM is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg    <= '0;
      pending_reg <= '0;
      lock_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (release_valid) head_reg <= head_reg + IDX_W'(1);
      if (state_reg == WAIT_MISS && dcMissDone) begin
        lock_reg <= LK_W'(LOCK_CYCLES - 1);
      end else if (state_reg == LOCK && lock_reg != '0) begin
        lock_reg <= lock_reg - LK_W'(1);
      end
    end
  end

  // Committing more stores than the queue can hold is a protocol error.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    pend_sum <= PW'(ENTRY_NUM));

  // The cache must never accept and reject the same write.
  a_ack_nack_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(dcWriteAck && dcWriteNack));

  // Commit never reports more stores than its width.
  a_commit_range: assert property (@(posedge clk) disable iff (!rst_n)
    int'(commitCount) <= COMMIT_WIDTH);

endmodule

// File: tb/tb_store_commit_drainer.sv
// Bench for store_commit_drainer: a store-queue model feeds the head entry,
// a cache model acks/nacks, and a scoreboard of committed entries is checked
// in order against every release.
module tb_store_commit_drainer;

  localparam int ENTRY_NUM    = 16;
  localparam int COMMIT_WIDTH = 2;
  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int LOCK_CYCLES  = 5;
  localparam int IDX_W = 4;
  localparam int CW_W  = 2;
  localparam int BE_W  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [CW_W-1:0]       commitCount = '0;
  logic [IDX_W-1:0]      sqHeadPtr;
  logic [ADDR_WIDTH-3:0] sqAddr;
  logic [DATA_WIDTH-1:0] sqData;
  logic [BE_W-1:0]       sqByteWE;
  logic                  sqCondEnabled;
  logic                  dcWriteReq;
  logic [ADDR_WIDTH-1:0] dcWriteAddr;
  logic [DATA_WIDTH-1:0] dcWriteData;
  logic [BE_W-1:0]       dcWriteByteWE;
  logic                  dcWriteAck;
  logic                  dcWriteNack;
  logic                  dcMissDone = 1'b0;
  logic                  releaseValid;
  logic [IDX_W:0]        pendingCount;
  logic                  drainEmpty;

  logic ack_en  = 1'b1;
  logic nack_en = 1'b0;

  store_commit_drainer #(
    .ENTRY_NUM(ENTRY_NUM), .COMMIT_WIDTH(COMMIT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .commitCount(commitCount), .sqHeadPtr(sqHeadPtr),
    .sqAddr(sqAddr), .sqData(sqData), .sqByteWE(sqByteWE),
    .sqCondEnabled(sqCondEnabled), .dcWriteReq(dcWriteReq),
    .dcWriteAddr(dcWriteAddr), .dcWriteData(dcWriteData),
    .dcWriteByteWE(dcWriteByteWE), .dcWriteAck(dcWriteAck),
    .dcWriteNack(dcWriteNack), .dcMissDone(dcMissDone),
    .releaseValid(releaseValid), .pendingCount(pendingCount),
    .drainEmpty(drainEmpty)
  );

  always #5 clk = ~clk;

  // Store-queue model: the head entry is read combinationally.
  logic [ADDR_WIDTH-3:0] mem_addr [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] mem_data [ENTRY_NUM];
  logic [BE_W-1:0]       mem_be   [ENTRY_NUM];
  logic                  mem_cond [ENTRY_NUM];

  assign sqAddr        = mem_addr[sqHeadPtr];
  assign sqData        = mem_data[sqHeadPtr];
  assign sqByteWE      = mem_be[sqHeadPtr];
  assign sqCondEnabled = mem_cond[sqHeadPtr];

  // Cache model answers only a live request.
  assign dcWriteAck  = dcWriteReq & ack_en;
  assign dcWriteNack = dcWriteReq & nack_en;

  typedef struct {
    int                    idx;
    logic [ADDR_WIDTH-3:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]       be;
    logic                  cond;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int tail = 0;
  int pend_model = 0;
  int peak = 0;
  int rel_cnt = 0;
  int rel_first = -1;
  int rel_last = -1;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill n entries at the bench tail, queue their expectations, commit them.
  task automatic commit(input int n, input logic c0, input logic c1);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.idx  = tail;
      e.addr = 30'($urandom);
      e.data = $urandom;
      e.be   = 4'($urandom_range(1, 15));
      e.cond = (i == 0) ? c0 : c1;
      mem_addr[tail] = e.addr;
      mem_data[tail] = e.data;
      mem_be[tail]   = e.be;
      mem_cond[tail] = e.cond;
      sb.push_back(e);
      tail = (tail + 1) % ENTRY_NUM;
    end
    commitCount = CW_W'(n);
    tick();
    commitCount = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!drainEmpty && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", drainEmpty, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pending model, write-output gating and scoreboard on release.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_model = 0;
    end else begin
      check_eq("pending", pendingCount, pend_model);
      if (int'(pendingCount) > peak) peak = int'(pendingCount);
      if (!dcWriteReq) check_eq("wr_gate", {dcWriteAddr, dcWriteData, dcWriteByteWE}, 0);
      if (releaseValid) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          check_eq("rel_idx", sqHeadPtr, mon_e.idx);
          check_eq("rel_req", dcWriteReq, mon_e.cond);
          if (mon_e.cond) begin
            check_eq("rel_addr", dcWriteAddr, {mon_e.addr, 2'b00});
            check_eq("rel_data", dcWriteData, mon_e.data);
            check_eq("rel_be", dcWriteByteWE, mon_e.be);
          end
          $display("[TB] release idx=%0d cond=%0b addr=%h data=%h be=%h cyc=%0d",
                   sqHeadPtr, mon_e.cond, dcWriteAddr, dcWriteData, dcWriteByteWE, cyc);
          rel_cnt++;
          if (rel_first < 0) rel_first = cyc;
          rel_last = cyc;
        end
      end
      pend_model = pend_model + int'(commitCount) - int'(releaseValid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int rel_before;
    logic [ADDR_WIDTH-1:0] exp_addr;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      mem_addr[i] = '0; mem_data[i] = '0; mem_be[i] = '0; mem_cond[i] = 1'b0;
    end
    tick();
    tick();
    // Reset state
    check_eq("rst_req", dcWriteReq, 0);
    check_eq("rst_release", releaseValid, 0);
    check_eq("rst_pending", pendingCount, 0);
    check_eq("rst_head", sqHeadPtr, 0);
    check_eq("rst_empty", drainEmpty, 1);
    check_eq("rst_addr", dcWriteAddr, 0);
    rst_n = 1'b1;
    tick();

    // Single store, first-request latency
    commit(1, 1'b1, 1'b0);                 // cycle 0 -> cycle 1
    check_eq("t1_c1_req", dcWriteReq, 0);
    check_eq("t1_c1_empty", drainEmpty, 0);
    tick();                                // cycle 2
    check_eq("t1_req", dcWriteReq, 1);
    exp_addr = {mem_addr[0], 2'b00};
    check_eq("t1_addr", dcWriteAddr, exp_addr);
    check_eq("t1_release", releaseValid, 1);
    tick();                                // cycle 3
    check_eq("t1_empty", drainEmpty, 1);

    // Full-rate burst of 16 with head wrap
    rel_cnt = 0; rel_first = -1; peak = 0;
    for (int i = 0; i < 8; i++) commit(2, 1'b1, 1'b1);
    wait_drain(40);
    check_eq("t2_releases", rel_cnt, 16);
    check_eq("t2_back_to_back", rel_last - rel_first, 15);
    check_eq("t2_peak", peak, 10);
    check_eq("t2_head", sqHeadPtr, tail);

    // Miss, refill, lock, retry
    ack_en = 1'b0; nack_en = 1'b1;
    k = tail;
    rel_cnt = 0;
    commit(1, 1'b1, 1'b0);                 // cycle 1
    tick();                                // cycle 2
    exp_addr = {mem_addr[k], 2'b00};
    check_eq("t3_req", dcWriteReq, 1);
    check_eq("t3_addr", dcWriteAddr, exp_addr);
    check_eq("t3_no_release", releaseValid, 0);
    tick();                                // cycle 3
    nack_en = 1'b0; ack_en = 1'b1;
    for (int c = 3; c < 12; c++) begin
      check_eq("t3_wait_req", dcWriteReq, 0);
      tick();
    end
    dcMissDone = 1'b1;                     // cycle 12
    check_eq("t3_done_req", dcWriteReq, 0);
    tick();
    dcMissDone = 1'b0;
    for (int c = 13; c < 17; c++) begin
      check_eq("t3_lock_req", dcWriteReq, 0);
      tick();
    end
    check_eq("t3_retry_req", dcWriteReq, 1);  // cycle 17
    check_eq("t3_retry_addr", dcWriteAddr, exp_addr);
    check_eq("t3_retry_data", dcWriteData, mem_data[k]);
    check_eq("t3_retry_release", releaseValid, 1);
    tick();
    check_eq("t3_empty", drainEmpty, 1);
    check_eq("t3_releases", rel_cnt, 1);

    // Failed store-conditional between two normal stores
    rel_cnt = 0; rel_first = -1;
    commit(2, 1'b1, 1'b0);
    commit(1, 1'b1, 1'b0);
    wait_drain(20);
    check_eq("t4_releases", rel_cnt, 3);
    check_eq("t4_back_to_back", rel_last - rel_first, 2);

    // Commit and release in the same cycle
    commit(2, 1'b1, 1'b1);                 // cycle 1
    commit(2, 1'b1, 1'b1);                 // cycle 2
    tick();                                // cycle 3
    check_eq("t5_pend3", pendingCount, 3);
    check_eq("t5_release", releaseValid, 1);
    commit(2, 1'b1, 1'b1);                 // cycle 4
    check_eq("t5_pend4", pendingCount, 4);
    wait_drain(20);

    // Reset pulse while in LOCK
    ack_en = 1'b0; nack_en = 1'b1;
    commit(1, 1'b1, 1'b0);                 // cycle 1
    tick();                                // cycle 2: nacked
    tick();                                // cycle 3: WAIT_MISS
    nack_en = 1'b0; ack_en = 1'b1;
    dcMissDone = 1'b1;
    tick();                                // cycle 4: LOCK
    dcMissDone = 1'b0;
    tick();                                // cycle 5: LOCK
    check_eq("t6_lock_pending", pendingCount, 1);
    rel_before = rel_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_req", dcWriteReq, 0);
    check_eq("t6_rst_release", releaseValid, 0);
    check_eq("t6_rst_pending", pendingCount, 0);
    check_eq("t6_rst_head", sqHeadPtr, 0);
    check_eq("t6_rst_empty", drainEmpty, 1);
    sb.delete();
    tail = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("t6_post_head", sqHeadPtr, 0);
    check_eq("t6_post_pending", pendingCount, 0);
    check_eq("t6_post_empty", drainEmpty, 1);
    check_eq("t6_no_release", rel_cnt, rel_before);
    commit(1, 1'b1, 1'b0);
    wait_drain(20);
    check_eq("t6_resume_head", sqHeadPtr, 1);
    check_eq("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
